// File: rtl/host_cpu_debug_pkg.sv
// Shared definitions for the host CPU debug command synchroniser.
//   state_t       : command FSM states (IDLE, PEND)
//   DEF_*         : default data/IR widths and the action-select bit
//   ir_onehot()   : one-hot decode of an IR value, sized for up to MAX_N_CMD channels;
//                   callers truncate the result to their own channel count.
package host_cpu_debug_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int unsigned DEF_DR_W       = 38;
  localparam int unsigned DEF_IR_W       = 2;
  localparam int unsigned DEF_ACTION_BIT = 37;
  localparam int unsigned MAX_N_CMD      = 256;

  function automatic logic [MAX_N_CMD-1:0] ir_onehot(input int unsigned idx);
    ir_onehot = MAX_N_CMD'(1) << idx;
  endfunction

endpackage

// File: rtl/host_cpu_debug_edge_sync.sv
// Synchronises one asynchronous JTAG strobe into clk and emits a registered one-cycle pulse
// on each qualified rising edge.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   async_in     : strobe level from the TCK domain
//   event_pulse  : one-cycle pulse, SYNC_STAGES+1 cycles after the input rise
module host_cpu_debug_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic event_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  // Tracks which chain stages hold real samples rather than reset zeros.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   synced;
  logic                   synced_valid;
  logic                   prev_q;
  logic                   armed_q;

  assign synced       = sync_q[SYNC_STAGES-1];
  assign synced_valid = fill_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      fill_q      <= '0;
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], async_in};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q      <= synced;
      // Only a genuinely sampled low arms the detector, so a strobe held high
      // across reset never looks like a fresh edge.
      if (synced_valid && !synced) begin
        armed_q <= 1'b1;
      end
      event_pulse <= armed_q && synced && !prev_q;
    end
  end

endmodule

// File: rtl/host_cpu_debug_cmd_sync.sv
// System-clock half of the debug module: captures JTAG commands, offers them to the debug
// core over valid/ready and fires one-hot take_action / take_no_action pulses.
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   vs_uir, vs_udr      : JTAG update-IR / update-DR strobes (async levels)
//   ir_in, sr           : JTAG IR and shift register (quasi-static)
//   cmd_ready           : debug core accepts the pending command
//   cmd_valid, busy     : high while a command is pending
//   cmd_ir, jdo         : IR and data word of the last accepted capture
//   take_action         : one-hot pulse on transfer when the action bit was 1
//   take_no_action      : one-hot pulse on transfer when the action bit was 0
//   overrun_cnt, overrun: saturating drop counter and sticky drop flag
module host_cpu_debug_cmd_sync
  import host_cpu_debug_pkg::*;
#(
  parameter int unsigned DR_W        = DEF_DR_W,
  parameter int unsigned IR_W        = DEF_IR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTION_BIT  = DEF_ACTION_BIT,
  parameter int unsigned OVR_W       = 8,
  localparam int unsigned N_CMD      = 1 << IR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vs_uir,
  input  logic             vs_udr,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [DR_W-1:0]  sr,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [IR_W-1:0]  cmd_ir,
  output logic [DR_W-1:0]  jdo,
  output logic [N_CMD-1:0] take_action,
  output logic [N_CMD-1:0] take_no_action,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             overrun
);

  logic             uir_ev;
  logic             udr_ev;
  state_t           state_q;
  state_t           state_d;
  logic [IR_W-1:0]  ir_q;
  logic             act_q;
  logic             transfer;
  logic             capture;
  logic             drop;
  logic [N_CMD-1:0] cmd_dec;

  host_cpu_debug_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uir_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (vs_uir),
    .event_pulse(uir_ev)
  );

  host_cpu_debug_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_udr_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (vs_udr),
    .event_pulse(udr_ev)
  );

  assign transfer = (state_q == PEND) && cmd_ready;
  assign capture  = (state_q == IDLE) && udr_ev;
  // A new command arriving while one is pending is lost, even if the pending
  // one is transferred in the same cycle.
  assign drop     = (state_q == PEND) && udr_ev;
  assign cmd_dec  = N_CMD'(ir_onehot(32'(cmd_ir)));

  assign cmd_valid = (state_q == PEND);
  assign busy      = (state_q == PEND);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (udr_ev) state_d = PEND;
      PEND:    if (cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ir_q           <= '0;
      cmd_ir         <= '0;
      jdo            <= '0;
      act_q          <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
      overrun        <= 1'b0;
      overrun_cnt    <= '0;
    end else begin
      state_q <= state_d;
      // Capture below reads the old ir_q when both strobes land together.
      if (uir_ev) begin
        ir_q <= ir_in;
      end
      if (capture) begin
        jdo    <= sr;
        cmd_ir <= ir_q;
        act_q  <= sr[ACTION_BIT];
      end
      take_action    <= (transfer && act_q)  ? cmd_dec : '0;
      take_no_action <= (transfer && !act_q) ? cmd_dec : '0;
      if (drop) begin
        overrun <= 1'b1;
        if (overrun_cnt != '1) begin
          overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
      end
    end
  end

endmodule
